// File: rtl/sram_ctrl.sv
// sram_ctrl: fixed-latency bridge from a 32-bit CPU load/store port to an asynchronous SRAM of 16 or 32 bits.
module sram_ctrl #(
  parameter int          SRAM_DW   = 16,
  parameter int          SRAM_AW   = 18,
  parameter int          WAIT      = 5,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdEn,
  input  logic               wrEn,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] sramAddr,
  inout  wire  [SRAM_DW-1:0] sramDq,
  output logic               sramWeN
);
  localparam int BEATS = 32 / SRAM_DW;
  localparam int CW = $clog2(WAIT);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, next_state;
  logic [CW-1:0] wait_cnt;
  logic beat, is_wr, req, wait_last, beat_last;
  logic [31:0] word_addr, wdata, rbuf, rword;
  logic [SRAM_DW-1:0] wslice;
  assign req = rdEn | wrEn;
  assign wait_last = wait_cnt == CW'(WAIT - 1);
  assign beat_last = beat == 1'(BEATS - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state == IDLE ? (req ? ACCESS : IDLE)
               : state == ACCESS ? (wait_last && beat_last ? DONE : ACCESS)
               : IDLE;
  end
  // Request is captured once on IDLE->ACCESS; rbuf collects read beats as they complete.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wait_cnt  <= '0;
      beat      <= 1'b0;
      is_wr     <= 1'b0;
      word_addr <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      readData  <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
      beat     <= 1'b0;
      if (req) begin
        is_wr     <= wrEn;
        word_addr <= (address - BASE_ADDR) >> 2;
        wdata     <= writeData;
        rbuf      <= '0;
      end
    end else if (state == ACCESS) begin
      wait_cnt <= wait_last ? '0 : wait_cnt + 1'b1;
      if (wait_last) begin
        beat <= beat_last ? 1'b0 : 1'b1;
        rbuf <= rword;
      end
      if (wait_last && beat_last && !is_wr) readData <= rword;
    end
  always_comb begin
    ready    = state == DONE || (state == IDLE && !req);
    sramAddr = state == ACCESS ? SRAM_AW'(word_addr * BEATS + 32'(beat)) : '0;
    sramWeN  = !(state == ACCESS && is_wr && !wait_last);
    wslice   = SRAM_DW'(wdata >> (beat ? SRAM_DW : 0));
    rword    = rbuf | (32'(sramDq) << (beat ? SRAM_DW : 0));
  end
  assign sramDq = (state == ACCESS && is_wr) ? wslice : 'z;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed checks of sram_ctrl in the 16-bit/WAIT=5 and 32-bit/WAIT=3 configurations.
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic rd0 = 0, wr0 = 0, rdy0, we0, oe0 = 0, probe0 = 0;
  logic [31:0] addr0 = '0, wd0 = '0, rdata0;
  logic [17:0] sa0;
  wire  [15:0] dq0;
  logic [15:0] mem0 [16] = '{default: '0};
  logic rd1 = 0, wr1 = 0, rdy1, we1;
  logic [31:0] addr1 = '0, wd1 = '0, rdata1;
  logic [17:0] sa1;
  wire  [31:0] dq1;
  logic [31:0] mem1 [16] = '{default: '0};
  sram_ctrl u0 (.clk(clk), .rst(rst), .rdEn(rd0), .wrEn(wr0), .address(addr0), .writeData(wd0),
                .readData(rdata0), .ready(rdy0), .sramAddr(sa0), .sramDq(dq0), .sramWeN(we0));
  sram_ctrl #(.SRAM_DW(32), .WAIT(3)) u1 (.clk(clk), .rst(rst), .rdEn(rd1), .wrEn(wr1), .address(addr1),
                .writeData(wd1), .readData(rdata1), .ready(rdy1), .sramAddr(sa1), .sramDq(dq1), .sramWeN(we1));
  // SRAM models: write on the clock edge while WE is low; probe drives a marker to test for a released bus
  assign dq0 = !oe0 ? 16'hzzzz : probe0 ? 16'h5AA5 : mem0[sa0[3:0]];
  always @(posedge clk) if (!we0) mem0[sa0[3:0]] <= dq0;
  always @(posedge clk) if (!we1) mem1[sa1[3:0]] <= dq1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic bus_released(input string tag);
    oe0 = 1; probe0 = 1;
    #1;
    check(tag, dq0, 16'h5AA5);
    oe0 = 0; probe0 = 0;
    #1;
  endtask
  task automatic start0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    step;
    rd0 = r; wr0 = w; addr0 = a; wd0 = d;
    #1;
    check("req0_ready", rdy0, 0);
  endtask
  task automatic read0(input logic [31:0] a, input int drop, input logic [31:0] exp, input string tag);
    oe0 = 1;
    start0(1, 0, a, 0);
    for (int c = 1; c <= 11; c++) begin
      step;
      if (c == drop) rd0 = 0;
      check("rd_wen", we0, 1);
      check("rd_ready", rdy0, c == 11);
      if (c == 11) check(tag, rdata0, exp);
    end
    oe0 = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #2;
    bus_released("rst_dq_z");
    check("rst_ready", rdy0, 1);
    check("rst_rdata", rdata0, 0);
    check("rst_wen", we0, 1);
    check("rst_addr", sa0, 0);
    step;
    rst = 1;
    start0(0, 1, 32'd1032, 32'hDEADBEEF);
    for (int c = 1; c <= 11; c++) begin
      step;
      if (c == 1) wr0 = 0;
      if (c <= 10) begin
        check("wr_addr", sa0, c <= 5 ? 4 : 5);
        check("wr_dq", dq0, c <= 5 ? 16'hBEEF : 16'hDEAD);
        check("wr_wen", we0, c % 5 == 0);
      end
      check("wr_ready", rdy0, c == 11);
    end
    check("mem4", mem0[4], 16'hBEEF);
    check("mem5", mem0[5], 16'hDEAD);
    step;
    bus_released("idle_dq_z");
    read0(32'd1032, 1, 32'hDEADBEEF, "rd_data");
    // both enables -> write; address 0 underflows to word 0x3FFFFF00
    start0(1, 1, 32'd0, 32'h0BADF00D);
    for (int c = 1; c <= 11; c++) begin
      step;
      if (c == 1) begin rd0 = 0; wr0 = 0; end
      if (c == 1) check("uf_addr_lo", sa0, 18'h3FE00);
      if (c == 6) check("uf_addr_hi", sa0, 18'h3FE01);
      check("both_ready", rdy0, c == 11);
    end
    check("both_rdata_hold", rdata0, 32'hDEADBEEF);
    check("mem0", mem0[0], 16'hF00D);
    check("mem1", mem0[1], 16'h0BAD);
    read0(32'd0, 3, 32'h0BADF00D, "drop_data");
    start0(0, 1, 32'd1044, 32'hDEADBEEF);
    for (int c = 1; c <= 5; c++) begin
      step;
      if (c == 1) wr0 = 0;
    end
    step;
    rst = 0;
    #1;
    check("mid_rst_wen", we0, 1);
    check("mid_rst_ready", rdy0, 1);
    check("mid_rst_rdata", rdata0, 0);
    check("mid_rst_addr", sa0, 0);
    bus_released("mid_rst_dq_z");
    step;
    rst = 1;
    check("abort_mem10", mem0[10], 16'hBEEF);
    check("abort_mem11", mem0[11], 16'h0000);
    read0(32'd1044, 1, 32'h0000BEEF, "abort_rd");
    step;
    wr1 = 1; addr1 = 32'd1036; wd1 = 32'hCAFEF00D;
    #1;
    check("w32_req_ready", rdy1, 0);
    for (int c = 1; c <= 10; c++) begin
      step;
      if (c == 6) wr1 = 0;
      if (c <= 3) begin
        check("w32_addr", sa1, 3);
        check("w32_dq", dq1, 32'hCAFEF00D);
        check("w32_wen", we1, c == 3);
      end
      check("w32_ready", rdy1, c == 4 || c >= 9);
    end
    check("mem1_3", mem1[3], 32'hCAFEF00D);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter SRAM_DW, default 16, SRAM data bus width; legal values 16 and 32; BEATS = 32/SRAM_DW.
REQ-002 Parameter SRAM_AW, default 18, SRAM address width.
REQ-003 Parameter WAIT, default 5, cycles per SRAM beat; minimum 2.
REQ-004 Parameter BASE_ADDR, default 1024, CPU byte address mapped to SRAM word 0.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 rdEn  in  1  MEM-stage read request.
REQ-008 wrEn  in  1  MEM-stage write request.
REQ-009 address  in  32  CPU byte address.
REQ-010 writeData  in  32  store data.
REQ-011 readData  out  32  load data; registered.
REQ-012 ready  out  1  0 = freeze pipeline; 1 = access complete or idle.
REQ-013 sramAddr  out  SRAM_AW  SRAM address.
REQ-014 sramDq  inout  SRAM_DW  SRAM data bus.
REQ-015 sramWeN  out  1  SRAM write enable, active-low.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-017 IDLE transitions: rdEn|wrEn -> ACCESS; otherwise remain in IDLE.
REQ-018 ACCESS transitions: go to DONE after BEATS*WAIT cycles.
REQ-019 DONE transitions: go to IDLE unconditionally.
REQ-020 ready SHALL be combinational: 1 in IDLE without a request and in DONE; 0 in IDLE with a request and in all ACCESS cycles.
REQ-021 Latency SHALL be fixed: request in cycle 0 -> ready=1 in cycle BEATS*WAIT+1.
REQ-022 The request type and the address and write data SHALL be latched on IDLE->ACCESS.
- Request changes during ACCESS are ignored; the transaction completes.
REQ-023 When rdEn and wrEn are both 1, the request SHALL be a write; readData SHALL be unchanged.
REQ-024 Address mapping SHALL be wordAddr = (address - BASE_ADDR) >> 2, mod 2^32 with no error on underflow.
- sramAddr = wordAddr*BEATS + beat, truncated to SRAM_AW.
REQ-025 Beat order SHALL be little-endian: beat 0 carries bits [SRAM_DW-1:0].
REQ-026 Each beat SHALL hold sramAddr stable for WAIT cycles, counted by a wait counter 0..WAIT-1.
- A beat counter 0..BEATS-1 advances when the wait counter wraps.
REQ-027 On writes, sramDq SHALL be driven with the current beat slice for the whole beat.
- sramWeN = 0 for wait counts 0..WAIT-2; sramWeN = 1 on the last count.
REQ-028 sramDq SHALL be high-Z on reads and outside ACCESS.
- sramWeN = 1 outside write beats.
REQ-029 On reads, the beat slice SHALL be sampled from sramDq at the edge ending the last cycle of each beat.
- readData is updated with the full word on entry to DONE.
REQ-030 readData SHALL hold its value until the next read completes.
REQ-031 A request present in the cycle after DONE SHALL start a new transaction.
- Back-to-back transactions produce exactly one ready=1 cycle between them.

Reset
REQ-032 rst=0 SHALL immediately force: state IDLE, both counters 0, readData=0, sramWeN=1, sramDq high-Z, sramAddr=0.
- As a consequence, ready=1 when no request is present.
REQ-033 Reset during ACCESS SHALL abort the transaction with no further SRAM activity.
- A read is then required to restart from IDLE after rst returns to 1.

Verification
REQ-034 Reset (defaults) -> assert rst=0 -> ready=1, readData=0x00000000, sramWeN=1, sramDq=Z.
REQ-035 Write (defaults) -> wrEn, address=1032, writeData=0xDEADBEEF:
- cycles 1-5: sramAddr=4, sramDq=0xBEEF, sramWeN low in cycles 1-4.
- cycles 6-10: sramAddr=5, sramDq=0xDEAD.
- ready=0 in cycles 0-10, ready=1 in cycle 11.
REQ-036 Read-back (defaults) -> rdEn, address=1032 against an SRAM model -> readData=0xDEADBEEF with ready=1 in cycle 11; sramWeN=1 throughout.
REQ-037 Request drop (defaults) -> rdEn deasserted in cycle 3 -> transaction still completes with ready=1 in cycle 11 and correct data.
REQ-038 Reset mid-write (defaults) -> rst=0 in cycle 6 -> sramWeN=1, sramDq=Z at once; after release, a read of 1032 returns the 0xBEEF low half written in beat 0.
REQ-039 SRAM_DW=32, WAIT=3:
- Single write -> one beat at sramAddr=wordAddr; ready=1 in cycle 4.
- Request held after DONE -> ready=1 for exactly one cycle, then 0 again as the next transaction starts.
